// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } arb_state_e;

    localparam int unsigned PRIO_RR    = 0;
    localparam int unsigned PRIO_FIXED = 1;

endpackage

// File: rtl/rr_pick.sv
// Combinational winner selection: first requesting index at or after ptr (round-robin),
// or lowest requesting index (fixed priority, ptr ignored).
module rr_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned  NUM_MASTERS   = 2,
    parameter int unsigned  PRIORITY_MODE = PRIO_RR,
    localparam int unsigned GW            = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [GW-1:0]          ptr,
    output logic [GW-1:0]          idx,
    output logic                   valid
);

    localparam logic [GW:0] NUM = (GW + 1)'(NUM_MASTERS);

    logic [GW-1:0] start;
    logic [GW:0]   cand;

    // Scan NUM_MASTERS candidates from the start index, wrapping past the last master.
    always_comb begin
        start = (PRIORITY_MODE == PRIO_FIXED) ? '0 : ptr;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
            cand = {1'b0, start} + (GW + 1)'(k);
            if (cand >= NUM) begin
                cand = cand - NUM;
            end
            if (!valid && req[cand[GW-1:0]]) begin
                valid = 1'b1;
                idx   = cand[GW-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// N-master arbiter in front of one byte-wide memory slave, with boot-lock to the loader.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned  NUM_MASTERS   = 2,
    parameter int unsigned  ADDR_WIDTH    = 32,
    parameter int unsigned  DATA_WIDTH    = 8,
    parameter int unsigned  PRIORITY_MODE = PRIO_RR,
    parameter int unsigned  BOOT_MASTER   = 1,
    localparam int unsigned GW            = $clog2(NUM_MASTERS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              boot_done,
    input  logic [NUM_MASTERS-1:0]            m_read_en,
    input  logic [NUM_MASTERS-1:0]            m_write_en,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata,
    output logic [NUM_MASTERS-1:0]            m_ready,
    output logic [ADDR_WIDTH-1:0]             s_addr,
    output logic [DATA_WIDTH-1:0]             s_wdata,
    output logic                              s_read_en,
    output logic                              s_write_en,
    input  logic [DATA_WIDTH-1:0]             s_rdata,
    input  logic                              s_ready,
    output logic [GW-1:0]                     grant,
    output logic                              busy,
    output logic                              proto_err
);

    localparam logic [GW-1:0] LAST = GW'(NUM_MASTERS - 1);

    arb_state_e                        state_q, state_d;
    logic [GW-1:0]                     grant_q, grant_d;
    logic [GW-1:0]                     ptr_q, ptr_d;
    logic                              is_wr_q, is_wr_d;
    logic                              proto_err_q, proto_err_d;
    logic [ADDR_WIDTH-1:0]             s_addr_q, s_addr_d;
    logic [DATA_WIDTH-1:0]             s_wdata_q, s_wdata_d;
    logic                              s_read_en_q, s_read_en_d;
    logic                              s_write_en_q, s_write_en_d;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata_q, m_rdata_d;
    logic [NUM_MASTERS-1:0]            m_ready_q, m_ready_d;

    logic [NUM_MASTERS-1:0] eligible;
    logic [GW-1:0]          pick_idx;
    logic                   pick_valid;

    // While boot is in progress only the loader master may win.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            eligible[i] = (m_read_en[i] | m_write_en[i]) & (boot_done | (i == BOOT_MASTER));
        end
    end

    rr_pick #(
        .NUM_MASTERS  (NUM_MASTERS),
        .PRIORITY_MODE(PRIORITY_MODE)
    ) u_pick (
        .req  (eligible),
        .ptr  (ptr_q),
        .idx  (pick_idx),
        .valid(pick_valid)
    );

    // Next-state and registered-output logic for the IDLE/ISSUE/WAIT/DONE sequence.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        ptr_d        = ptr_q;
        is_wr_d      = is_wr_q;
        proto_err_d  = proto_err_q;
        s_addr_d     = s_addr_q;
        s_wdata_d    = s_wdata_q;
        s_read_en_d  = s_read_en_q;
        s_write_en_d = s_write_en_q;
        m_rdata_d    = m_rdata_q;
        m_ready_d    = '0;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    // Operation is latched at grant so a dropped request still completes.
                    is_wr_d = m_write_en[pick_idx];
                    if (m_read_en[pick_idx] && m_write_en[pick_idx]) begin
                        proto_err_d = 1'b1;
                    end
                    state_d = StIssue;
                end
            end
            StIssue: begin
                s_addr_d     = m_addr[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
                s_wdata_d    = m_wdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
                s_write_en_d = is_wr_q;
                s_read_en_d  = !is_wr_q;
                state_d      = StWait;
            end
            StWait: begin
                if (s_ready) begin
                    s_read_en_d  = 1'b0;
                    s_write_en_d = 1'b0;
                    if (!is_wr_q) begin
                        m_rdata_d[grant_q*DATA_WIDTH +: DATA_WIDTH] = s_rdata;
                    end
                    m_ready_d[grant_q] = 1'b1;
                    state_d            = StDone;
                end
            end
            StDone: begin
                ptr_d   = (grant_q == LAST) ? '0 : grant_q + 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register; reset abandons any transaction without an m_ready pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            ptr_q        <= '0;
            is_wr_q      <= 1'b0;
            proto_err_q  <= 1'b0;
            s_addr_q     <= '0;
            s_wdata_q    <= '0;
            s_read_en_q  <= 1'b0;
            s_write_en_q <= 1'b0;
            m_rdata_q    <= '0;
            m_ready_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            ptr_q        <= ptr_d;
            is_wr_q      <= is_wr_d;
            proto_err_q  <= proto_err_d;
            s_addr_q     <= s_addr_d;
            s_wdata_q    <= s_wdata_d;
            s_read_en_q  <= s_read_en_d;
            s_write_en_q <= s_write_en_d;
            m_rdata_q    <= m_rdata_d;
            m_ready_q    <= m_ready_d;
        end
    end

    assign m_rdata    = m_rdata_q;
    assign m_ready    = m_ready_q;
    assign s_addr     = s_addr_q;
    assign s_wdata    = s_wdata_q;
    assign s_read_en  = s_read_en_q;
    assign s_write_en = s_write_en_q;
    assign grant      = grant_q;
    assign busy       = (state_q != StIdle);
    assign proto_err  = proto_err_q;

endmodule
